// File: rtl/postprocess_scheduler.sv
// Post-process scheduler: sequences one layer of accumulator beats
// through the bias/ReLU/BN datapath. It supplies the per-channel bias
// with each beat and the BN scale/offset one cycle later so that they
// line up with the datapath's registered ReLU stage.
module postprocess_scheduler #(
    parameter  int POX    = 3,
    parameter  int NUM_OC = 16,
    localparam int ADDR_W = (NUM_OC > 1) ? $clog2(NUM_OC) : 1,
    localparam int DW     = POX * 16
) (
    input  logic              clk,
    input  logic              rst,
    // parameter table write port
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [15:0]       cfg_k,
    input  logic [15:0]       cfg_b,
    input  logic [15:0]       cfg_bias,
    // layer shape
    input  logic [ADDR_W:0]   cfg_num_oc,
    input  logic [15:0]       cfg_beats,
    // run control
    input  logic              start,
    output logic              busy,
    output logic              done,
    // accumulator stream
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    // stage-1 feed
    output logic [DW-1:0]     pp_data,
    output logic              pp_valid,
    output logic [DW-1:0]     pp_bias,
    // stage-2 BN parameters
    output logic [15:0]       pp_k,
    output logic [15:0]       pp_b
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // NUM_OC expressed at counter width; ADDR_W+1 bits always hold it.
    localparam logic [ADDR_W:0] NUM_OC_W = (ADDR_W + 1)'(NUM_OC);

    // Scheduler register plus the 2-cycle datapath.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

    state_t            state;
    logic [15:0]       beat_cnt;
    logic [15:0]       beats_q;
    logic [ADDR_W:0]   oc_cnt;
    logic [ADDR_W:0]   num_oc_q;
    logic [1:0]        drain_cnt;

    logic [15:0]       tbl_k    [NUM_OC];
    logic [15:0]       tbl_b    [NUM_OC];
    logic [15:0]       tbl_bias [NUM_OC];

    logic              accept;
    logic              last_beat;
    logic              last_oc;
    logic              cfg_ok;
    logic              addr_ok;
    logic [ADDR_W-1:0] oc_idx;
    logic [ADDR_W-1:0] kb_idx;

    // in_ready is a registered copy of (state == S_RUN).
    assign accept    = in_ready & in_valid;
    assign last_beat = (beat_cnt == beats_q - 16'd1);
    assign last_oc   = (oc_cnt == num_oc_q - 1'b1);
    assign oc_idx    = oc_cnt[ADDR_W-1:0];

    // A layer is runnable only with 1..NUM_OC channels and a nonzero beat count.
    assign cfg_ok  = (cfg_num_oc != '0) && (cfg_num_oc <= NUM_OC_W) && (cfg_beats != 16'd0);
    assign addr_ok = ({1'b0, cfg_addr} < NUM_OC_W);

    // Run-control FSM with beat/channel counters and registered status outputs.
    always_ff @(posedge clk) begin
        // NOTE: every register here is assigned with <= so all of them sample
        // the pre-edge values; a blocking = would let later lines see new state.
        if (rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            beats_q   <= '0;
            oc_cnt    <= '0;
            num_oc_q  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state    <= S_RUN;
                            num_oc_q <= cfg_num_oc;
                            beats_q  <= cfg_beats;
                            beat_cnt <= '0;
                            oc_cnt   <= '0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end else begin
                            // Degenerate layer: report completion with no beats.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (last_oc) begin
                                // Final beat of the layer: stop accepting at once.
                                state     <= S_DRAIN;
                                drain_cnt <= '0;
                                in_ready  <= 1'b0;
                            end else begin
                                oc_cnt <= oc_cnt + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel parameter table; writable only while idle.
    always_ff @(posedge clk) begin
        // NOTE: this table is cleared on reset on purpose, which forces it into
        // flops; a table that needs no reset value could map to RAM instead.
        if (rst) begin
            for (int i = 0; i < NUM_OC; i++) begin
                tbl_k[i]    <= '0;
                tbl_b[i]    <= '0;
                tbl_bias[i] <= '0;
            end
        end else if (state == S_IDLE && cfg_we && addr_ok) begin
            tbl_k[cfg_addr]    <= cfg_k;
            tbl_b[cfg_addr]    <= cfg_b;
            tbl_bias[cfg_addr] <= cfg_bias;
        end
    end

    // Stage-1 feed on acceptance, then BN parameters one cycle behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pp_valid <= 1'b0;
            pp_data  <= '0;
            pp_bias  <= '0;
            pp_k     <= '0;
            pp_b     <= '0;
            kb_idx   <= '0;
        end else begin
            pp_valid <= accept;
            if (accept) begin
                pp_data <= in_data;
                pp_bias <= {POX{tbl_bias[oc_idx]}};
                kb_idx  <= oc_idx;
            end
            if (pp_valid) begin
                pp_k <= tbl_k[kb_idx];
                pp_b <= tbl_b[kb_idx];
            end
        end
    end

endmodule

// File: tb/tb_postprocess_scheduler.sv
// Scoreboard bench for postprocess_scheduler: the driver pushes the
// expected feed for each accepted beat, computed from a table model and
// the layer shape; a negedge monitor pops and compares.
module tb_postprocess_scheduler;

    localparam int POX    = 3;
    localparam int NUM_OC = 16;
    localparam int ADDR_W = 4;
    localparam int DW     = POX * 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [15:0]       cfg_k = '0;
    logic [15:0]       cfg_b = '0;
    logic [15:0]       cfg_bias = '0;
    logic [ADDR_W:0]   cfg_num_oc = '0;
    logic [15:0]       cfg_beats = '0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     pp_data;
    logic              pp_valid;
    logic [DW-1:0]     pp_bias;
    logic [15:0]       pp_k;
    logic [15:0]       pp_b;

    postprocess_scheduler #(.POX(POX), .NUM_OC(NUM_OC)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_k(cfg_k), .cfg_b(cfg_b), .cfg_bias(cfg_bias),
        .cfg_num_oc(cfg_num_oc), .cfg_beats(cfg_beats),
        .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pp_data(pp_data), .pp_valid(pp_valid), .pp_bias(pp_bias),
        .pp_k(pp_k), .pp_b(pp_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DW-1:0] bias;
        logic [15:0]   k;
        logic [15:0]   b;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl_k    [NUM_OC];
    logic [15:0] mdl_b    [NUM_OC];
    logic [15:0] mdl_bias [NUM_OC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compares feed on pp_valid, BN parameters one cycle later,
    // and that nothing moves when no beat was accepted.
    initial begin : monitor
        exp_t          pend;
        exp_t          e;
        logic          kb_pending = 1'b0;
        logic [DW-1:0] last_data  = '0;
        logic [DW-1:0] last_bias  = '0;
        logic [15:0]   last_k     = '0;
        logic [15:0]   last_b     = '0;
        forever begin
            @(negedge clk);
            if (kb_pending) begin
                check("pp_k_aligned", pp_k, pend.k);
                check("pp_b_aligned", pp_b, pend.b);
                last_k     = pend.k;
                last_b     = pend.b;
                kb_pending = 1'b0;
            end else begin
                check("pp_k_hold", pp_k, last_k);
                check("pp_b_hold", pp_b, last_b);
            end
            if (pp_valid) begin
                if (exp_q.size() == 0) begin
                    check("pp_valid_unexpected", 1, 0);
                    last_data = pp_data;
                    last_bias = pp_bias;
                end else begin
                    e = exp_q.pop_front();
                    check("pp_data", pp_data, e.data);
                    check("pp_bias", pp_bias, e.bias);
                    last_data  = e.data;
                    last_bias  = e.bias;
                    pend       = e;
                    kb_pending = 1'b1;
                end
            end else begin
                check("pp_data_hold", pp_data, last_data);
                check("pp_bias_hold", pp_bias, last_bias);
            end
            // rst high now means the coming edge clears everything.
            if (rst) begin
                exp_q.delete();
                kb_pending = 1'b0;
                last_data  = '0;
                last_bias  = '0;
                last_k     = '0;
                last_b     = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input logic [15:0] k, input logic [15:0] b,
                             input logic [15:0] bias);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_k    = k;
        cfg_b    = b;
        cfg_bias = bias;
        step();
        cfg_we = 1'b0;
        mdl_k[addr]    = k;
        mdl_b[addr]    = b;
        mdl_bias[addr] = bias;
    endtask

    // mode 0: back-to-back, 1: alternating valid, 2: random valid.
    // disturb: pulse start and a table write while the layer is running.
    task automatic run_layer(input int n, input int bts, input int mode, input bit disturb);
        int   total = n * bts;
        int   acc   = 0;
        int   cyc   = 0;
        int   waitc = 1;
        int   ch;
        logic vld;
        exp_t e;
        cfg_num_oc = (ADDR_W + 1)'(n);
        cfg_beats  = 16'(bts);
        start      = 1'b1;
        in_valid   = 1'b0;
        step();
        start = 1'b0;
        check("busy_on_start", busy, 1);
        check("in_ready_on_start", in_ready, 1);
        while (acc < total && cyc < 4000) begin
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            in_valid = vld;
            in_data  = DW'({$urandom(), $urandom()});
            if (disturb && cyc == 1) begin
                cfg_we   = 1'b1;
                cfg_addr = '0;
                cfg_k    = 16'hDEAD;
                cfg_b    = 16'hBEEF;
                cfg_bias = 16'h7777;
                start    = 1'b1;
            end
            if (vld && in_ready) begin
                ch     = acc / bts;
                e.data = in_data;
                e.bias = {POX{mdl_bias[ch]}};
                e.k    = mdl_k[ch];
                e.b    = mdl_b[ch];
                exp_q.push_back(e);
                acc++;
            end
            step();
            cfg_we = 1'b0;
            start  = 1'b0;
            cyc++;
        end
        check("beats_accepted", acc, total);
        // Past the last acceptance edge: input must be closed, drain running.
        check("in_ready_after_last", in_ready, 0);
        check("busy_in_drain", busy, 1);
        in_valid = 1'b1;
        while (!done && waitc < 20) begin
            step();
            waitc++;
        end
        in_valid = 1'b0;
        check("done_latency", waitc, 4);
        check("busy_at_done", busy, 0);
        step();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic bad_start(input int n, input int bts);
        cfg_num_oc = (ADDR_W + 1)'(n);
        cfg_beats  = 16'(bts);
        start      = 1'b1;
        in_valid   = 1'b1;
        step();
        start = 1'b0;
        check("bad_done", done, 1);
        check("bad_busy", busy, 0);
        check("bad_in_ready", in_ready, 0);
        step();
        in_valid = 1'b0;
        check("bad_done_drop", done, 0);
        check("bad_busy_idle", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_pp_valid"}, pp_valid, 0);
        check({tag, "_pp_data"}, pp_data, 0);
        check({tag, "_pp_bias"}, pp_bias, 0);
        check({tag, "_pp_k"}, pp_k, 0);
        check({tag, "_pp_b"}, pp_b, 0);
    endtask

    initial begin : driver
        for (int i = 0; i < NUM_OC; i++) begin
            mdl_k[i]    = '0;
            mdl_b[i]    = '0;
            mdl_bias[i] = '0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Beats offered while idle must be dropped.
        in_valid = 1'b1;
        in_data  = DW'(48'h1234_5678_9ABC);
        step();
        step();
        in_valid = 1'b0;
        check("idle_in_ready", in_ready, 0);

        // Two-channel layer, back-to-back then with gaps.
        cfg_write(0, 16'h1000, 16'h0010, 16'h0005);
        cfg_write(1, 16'h2000, 16'h0020, 16'h000A);
        run_layer(2, 2, 0, 1'b0);
        run_layer(2, 2, 1, 1'b0);

        // Degenerate shapes complete immediately.
        bad_start(2, 0);
        bad_start(0, 2);
        bad_start(NUM_OC + 1, 2);

        // Start and table writes during a run are ignored.
        run_layer(2, 2, 0, 1'b1);
        run_layer(1, 3, 2, 1'b0);

        // Reset after one accepted beat, with competing inputs in that cycle.
        cfg_num_oc = 5'd2;
        cfg_beats  = 16'd2;
        start      = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'({$urandom(), $urandom()});
        begin
            exp_t e;
            e.data = in_data;
            e.bias = {POX{mdl_bias[0]}};
            e.k    = mdl_k[0];
            e.b    = mdl_b[0];
            exp_q.push_back(e);
        end
        step();
        rst      = 1'b1;
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 4'd1;
        cfg_k    = 16'h5555;
        step();
        rst    = 1'b0;
        start  = 1'b0;
        cfg_we = 1'b0;
        in_valid = 1'b0;
        check_all_zero("midrun_reset");
        for (int i = 0; i < NUM_OC; i++) begin
            mdl_k[i]    = '0;
            mdl_b[i]    = '0;
            mdl_bias[i] = '0;
        end
        // Table must read back as zero after reset.
        run_layer(2, 2, 2, 1'b0);

        // Full-depth layer, one beat per channel, distinct entries.
        for (int i = 0; i < NUM_OC; i++)
            cfg_write(i, 16'($urandom()), 16'($urandom()), 16'($urandom()));
        run_layer(NUM_OC, 1, 0, 1'b0);
        run_layer(3, 5, 2, 1'b0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a run never completes.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/postprocess_scheduler.md
POSTPROCESS_SCHEDULER -- requirements
Module: postprocess_scheduler

Interface
REQ-001 SHALL have parameter POX, default 3: output pixels per beat; data width POX*16.
REQ-002 SHALL have parameter NUM_OC, default 16: parameter-table depth (output channels); ADDR_W = clog2(NUM_OC).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cfg_we, input, 1: table write strobe.
REQ-006 SHALL have ports cfg_addr (input, ADDR_W), cfg_k (input, 16), cfg_b (input, 16) and cfg_bias (input, 16): table write address and entry fields.
REQ-007 SHALL have ports cfg_num_oc (input, ADDR_W+1) and cfg_beats (input, 16): channels per layer and beats per channel.
REQ-008 SHALL have ports start (input, 1), busy (output, 1) and done (output, 1): run control; done is a one-cycle completion pulse.
REQ-009 SHALL have ports in_data (input, POX*16), in_valid (input, 1) and in_ready (output, 1): accumulator stream.
REQ-010 SHALL have ports pp_data (output, POX*16), pp_valid (output, 1) and pp_bias (output, POX*16): stage-1 feed to the bias/ReLU/BN datapath.
REQ-011 SHALL have ports pp_k (output, 16) and pp_b (output, 16): stage-2 BN scale and offset.

Function
REQ-012 SHALL hold a NUM_OC-entry table of {k, b, bias}; cfg_we=1 in IDLE writes table[cfg_addr] at the clock edge; cfg_we is ignored in every other state.
REQ-013 SHALL implement the state machine IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN SHALL occur when start=1, cfg_num_oc is in 1..NUM_OC and cfg_beats is nonzero; on entry, cfg_num_oc and cfg_beats are latched, and beat_cnt and oc_cnt are cleared to 0.
REQ-015 With start=1 and cfg_num_oc=0, cfg_beats=0 or cfg_num_oc>NUM_OC, the block SHALL go IDLE->DONE, giving a done pulse with no output beats.
REQ-016 in_ready SHALL equal 1 exactly in RUN; busy SHALL equal 1 in RUN and DRAIN.
REQ-017 A beat SHALL be accepted when in_valid=1 and in_ready=1.
REQ-018 Beats presented in other states SHALL be dropped, and pp_valid SHALL stay 0 for them.
REQ-019 Per accepted beat, the next cycle SHALL give: pp_valid=1, pp_data=in_data, and pp_bias = table[oc_cnt].bias replicated POX times.
REQ-020 When no beat is accepted, pp_valid SHALL be 0; pp_data and pp_bias SHALL hold their previous values.
REQ-021 pp_k and pp_b SHALL update one cycle after pp_valid=1, from table[channel of that beat].
REQ-022 This keeps pp_k and pp_b aligned with the datapath's registered ReLU stage; they SHALL hold their values otherwise.
REQ-023 On acceptance, beat_cnt SHALL increment. At beat_cnt=cfg_beats-1 it SHALL wrap to 0 and oc_cnt SHALL increment.
REQ-024 Acceptance of the last beat (oc_cnt=cfg_num_oc-1 and beat_cnt=cfg_beats-1) SHALL move RUN->DRAIN in the same edge; in_ready SHALL be 0 from the next cycle.
REQ-025 DRAIN SHALL last exactly 3 cycles, which covers the scheduler register plus the 2-cycle datapath; the block SHALL then enter DONE.
REQ-026 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 Unsigned counter arithmetic SHALL be used; no counter exceeds its latched bound.
REQ-029 in_valid gaps in RUN SHALL stall the counters with no timeout.
REQ-030 Total beats per run SHALL equal cfg_num_oc*cfg_beats exactly.

Reset
REQ-031 When rst=1 at an edge, the block SHALL go to IDLE, including mid-run.
REQ-032 On that reset, counters SHALL clear; busy, done, in_ready and pp_valid SHALL be 0; and pp_data, pp_bias, pp_k, pp_b and every table entry SHALL be 0.
REQ-033 rst SHALL take priority over start, cfg_we and in_valid in the same cycle.

Verification
REQ-034 Write table[0]={k=0x1000,b=0x0010,bias=0x0005} and table[1]={k=0x2000,b=0x0020,bias=0x000A}; num_oc=2, beats=2; stream 4 beats back-to-back. Required: pp_bias=0x0005 replicated for beats 0-1 and 0x000A for beats 2-3; pp_k=0x1000 then 0x2000, each one cycle after its pp_valid; done 4 cycles after the last acceptance.
REQ-035 Same configuration with in_valid toggling 1,0,1,0. Required: pp_valid mirrors acceptances one cycle later; counters stall on gaps; 4 beats total.
REQ-036 start with cfg_beats=0. Required: done=1 next cycle; busy and pp_valid never rise.
REQ-037 cfg_we asserted and start pulsed during RUN. Required: table unchanged; run unaffected.
REQ-038 rst asserted after 1 of 4 beats. Required: IDLE next cycle; all outputs and table 0; a new start runs cleanly.
REQ-039 num_oc=NUM_OC=16, beats=1. Required: oc_cnt reaches 15 without wrap; entry 15 is used for the last beat; exactly 16 pp_valid pulses.
